multicycle_ctrl: RTL and testbench

//  Moore FSM sequencing a multi-cycle MIPS-subset datapath: PC, IR, register file, ALU, memory port and
//  the 16->32 immediate extender. Selects extension mode (sign/zero/upper) per opcode and steps each

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Purpose : Moore control FSM for a multi-cycle MIPS-subset datapath (IF/ID/EX/MEM/WB sequencing + extender mode).
// Latency : 3..5 cycles per instruction (j/beq/bne 3, R/I/sw 4, lw 5), plus one cycle per memory wait.
// Backpr. : IF, MRD and MWR hold with mem_req_o high until mem_ready_i; only reset can abandon a request.
//
// Ports:
//   clk_i, rst_i (sync, active-low)      opcode_i (IR[31:26], valid from ID)
//   mem_ready_i, zero_i                  memory handshake / ALU zero flag
//   mem_req_o, mem_we_o, iord_o          memory port control
//   ir_write_o, pc_write_o, pc_src_o     IR / PC update control
//   ext_op_o, alu_src_a_o, alu_src_b_o,  extender and ALU control
//   alu_op_o
//   reg_dst_o, mem_to_reg_o, reg_write_o register-file write-back control
//   done_o, illegal_o                    per-instruction status pulses
module multicycle_ctrl #(
    parameter int OPW = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           mem_ready_i,
    input  logic           zero_i,
    output logic           mem_req_o,
    output logic           mem_we_o,
    output logic           iord_o,
    output logic           ir_write_o,
    output logic           pc_write_o,
    output logic [1:0]     pc_src_o,
    output logic [1:0]     ext_op_o,
    output logic [1:0]     alu_src_b_o,
    output logic           alu_src_a_o,
    output logic [2:0]     alu_op_o,
    output logic           reg_dst_o,
    output logic           mem_to_reg_o,
    output logic           reg_write_o,
    output logic           done_o,
    output logic           illegal_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_IF, S_ID, S_EXR, S_EXI, S_EXM, S_MRD,
        S_MWR, S_WBR, S_WBI, S_WBM, S_BR, S_JMP
    } state_t;

    localparam logic [OPW-1:0] OP_R    = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'h05);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_SLTI = OPW'(6'h0A);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(6'h0C);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'h0D);
    localparam logic [OPW-1:0] OP_LUI  = OPW'(6'h0F);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'h23);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'h2B);

    state_t         state_q, state_d;
    logic [OPW-1:0] opcode_q;
    logic [OPW-1:0] op_cur;

    // The latch only captures at the end of ID, so during ID itself the
    // live IR opcode is the one being decoded; afterwards the latched copy.
    assign op_cur = (state_q == S_ID) ? opcode_i : opcode_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                opcode_q <= opcode_i;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF:   if (mem_ready_i) state_d = S_ID;
            S_ID: begin
                case (opcode_i)
                    OP_R:                                     state_d = S_EXR;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXI;
                    OP_LW, OP_SW:                             state_d = S_EXM;
                    OP_BEQ, OP_BNE:                           state_d = S_BR;
                    OP_J:                                     state_d = S_JMP;
                    default:                                  state_d = S_IF; // dropped
                endcase
            end
            S_EXR:  state_d = S_WBR;
            S_EXI:  state_d = S_WBI;
            S_EXM:  state_d = (opcode_q == OP_SW) ? S_MWR : S_MRD;
            S_MRD:  if (mem_ready_i) state_d = S_WBM;
            S_MWR:  if (mem_ready_i) state_d = S_IF;
            S_WBR, S_WBI, S_WBM, S_BR, S_JMP: state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        ext_op_o     = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_op_o     = 3'b000;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        done_o       = 1'b0;
        illegal_o    = 1'b0;

        // Extender mode is meaningful from ID onwards only.
        if (state_q != S_IDLE && state_q != S_IF) begin
            case (op_cur)
                OP_ANDI, OP_ORI: ext_op_o = 2'b01;
                OP_LUI:          ext_op_o = 2'b10;
                default:         ext_op_o = 2'b00;
            endcase
        end

        case (state_q)
            S_IF: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;          // PC + 4
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_ID: begin
                alu_src_b_o = 2'b11;          // branch target precompute
                case (opcode_i)
                    OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI,
                    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: illegal_o = 1'b0;
                    default:                            illegal_o = 1'b1;
                endcase
            end
            S_EXR: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b010;
            end
            S_EXI: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (opcode_q)
                    OP_SLTI: alu_op_o = 3'b011;
                    OP_ANDI: alu_op_o = 3'b100;
                    OP_ORI:  alu_op_o = 3'b101;
                    default: alu_op_o = 3'b000; // addi, and lui as ext + $zero
                endcase
            end
            S_EXM: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MRD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            S_MWR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
                done_o    = mem_ready_i;
            end
            S_WBR: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                done_o      = 1'b1;
            end
            S_WBI: begin
                reg_write_o = 1'b1;
                done_o      = 1'b1;
            end
            S_WBM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                done_o       = 1'b1;
            end
            S_BR: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b001;
                pc_src_o    = 2'b01;
                // Only beq/bne can reach BR.
                pc_write_o  = (opcode_q == OP_BEQ) ? zero_i : ~zero_i;
                done_o      = 1'b1;
            end
            S_JMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
                done_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : directed table-driven check of multicycle_ctrl, one vector per clock cycle.
// Latency : each vector is driven on the falling edge and compared 1 ns later.
// Backpr. : memory waits are modelled by holding mem_ready_i low in the vectors.
module tb_multicycle_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic [5:0] opcode_i;
    logic       mem_ready_i;
    logic       zero_i;
    logic       mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o;
    logic [1:0] pc_src_o, ext_op_o, alu_src_b_o;
    logic       alu_src_a_o;
    logic [2:0] alu_op_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, done_o, illegal_o;

    multicycle_ctrl #(.OPW(6)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .mem_ready_i  (mem_ready_i),
        .zero_i       (zero_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .iord_o       (iord_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .ext_op_o     (ext_op_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_op_o     (alu_op_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .done_o       (done_o),
        .illegal_o    (illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic        zero;
        logic [19:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    // Output vector layout:
    // {req, we, iord, irw, pcw, pcsrc[2], ext[2], srcb[2], srca, aluop[3], rdst, m2r, rw, done, ill}
    function automatic logic [19:0] mk(input logic req, we, iord, irw, pcw,
                                       input logic [1:0] pcsrc, ext, srcb,
                                       input logic srca, input logic [2:0] aop,
                                       input logic rdst, m2r, rw, dn, ill);
        return {req, we, iord, irw, pcw, pcsrc, ext, srcb, srca, aop, rdst, m2r, rw, dn, ill};
    endfunction

    function automatic logic [19:0] actual();
        return {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o, ext_op_o,
                alu_src_b_o, alu_src_a_o, alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o,
                done_o, illegal_o};
    endfunction

    // Hand-derived expected output patterns per state.
    function automatic logic [19:0] e_id(input logic [1:0] e);
        return mk(0,0,0,0,0, 2'b00, e, 2'b11, 0, 3'b000, 0,0,0,0,0);
    endfunction
    function automatic logic [19:0] e_exi(input logic [1:0] e, input logic [2:0] a);
        return mk(0,0,0,0,0, 2'b00, e, 2'b10, 1, a, 0,0,0,0,0);
    endfunction
    function automatic logic [19:0] e_wbi(input logic [1:0] e);
        return mk(0,0,0,0,0, 2'b00, e, 2'b00, 0, 3'b000, 0,0,1,1,0);
    endfunction
    function automatic logic [19:0] e_br(input logic p);
        return mk(0,0,0,0,p, 2'b01, 2'b00, 2'b00, 1, 3'b001, 0,0,0,1,0);
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic zero, input logic [19:0] exp);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.zero = zero; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [19:0] E_IDLE, E_IFW, E_IFR, E_IDILL, E_EXR, E_EXM, E_MRD, E_MWR, E_MWRD;
    logic [19:0] E_WBR, E_WBM, E_JMP;

    initial begin
        int cyc;
        bit seen;

        E_IDLE  = '0;
        E_IFW   = mk(1,0,0,0,0, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0,0,0,0,0);
        E_IFR   = mk(1,0,0,1,1, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0,0,0,0,0);
        E_IDILL = mk(0,0,0,0,0, 2'b00, 2'b00, 2'b11, 0, 3'b000, 0,0,0,0,1);
        E_EXR   = mk(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 0,0,0,0,0);
        E_EXM   = mk(0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1, 3'b000, 0,0,0,0,0);
        E_MRD   = mk(1,0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0,0,0,0,0);
        E_MWR   = mk(1,1,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0,0,0,0,0);
        E_MWRD  = mk(1,1,1,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0,0,0,1,0);
        E_WBR   = mk(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 1,0,1,1,0);
        E_WBM   = mk(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0,1,1,1,0);
        E_JMP   = mk(0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0, 3'b000, 0,0,0,1,0);

        // reset, then release
        add(0, 6'h00, 0, 0, E_IDLE);
        add(1, 6'h00, 0, 0, E_IDLE);
        // addi
        add(1, 6'h08, 1, 0, E_IFR);
        add(1, 6'h08, 0, 0, e_id(2'b00));
        add(1, 6'h08, 0, 0, e_exi(2'b00, 3'b000));
        add(1, 6'h08, 0, 0, e_wbi(2'b00));
        // ori
        add(1, 6'h0D, 1, 0, E_IFR);
        add(1, 6'h0D, 0, 0, e_id(2'b01));
        add(1, 6'h0D, 0, 0, e_exi(2'b01, 3'b101));
        add(1, 6'h0D, 0, 0, e_wbi(2'b01));
        // lui; opcode_i changes after ID so the latched copy must be used
        add(1, 6'h0F, 1, 0, E_IFR);
        add(1, 6'h0F, 0, 0, e_id(2'b10));
        add(1, 6'h00, 0, 0, e_exi(2'b10, 3'b000));
        add(1, 6'h00, 0, 0, e_wbi(2'b10));
        // lw: 2 fetch waits, 3 data waits -> 10 cycles
        add(1, 6'h23, 0, 0, E_IFW);
        add(1, 6'h23, 0, 0, E_IFW);
        add(1, 6'h23, 1, 0, E_IFR);
        add(1, 6'h23, 0, 0, e_id(2'b00));
        add(1, 6'h23, 0, 0, E_EXM);
        add(1, 6'h23, 0, 0, E_MRD);
        add(1, 6'h23, 0, 0, E_MRD);
        add(1, 6'h23, 0, 0, E_MRD);
        add(1, 6'h23, 1, 0, E_MRD);
        add(1, 6'h23, 0, 0, E_WBM);
        // beq taken, bne not taken (zero=1)
        add(1, 6'h04, 1, 1, E_IFR);
        add(1, 6'h04, 0, 1, e_id(2'b00));
        add(1, 6'h04, 0, 1, e_br(1'b1));
        add(1, 6'h05, 1, 1, E_IFR);
        add(1, 6'h05, 0, 1, e_id(2'b00));
        add(1, 6'h05, 0, 1, e_br(1'b0));
        // illegal opcode: dropped, straight back to IF
        add(1, 6'h3F, 1, 0, E_IFR);
        add(1, 6'h3F, 0, 0, E_IDILL);
        add(1, 6'h3F, 0, 0, E_IFW);
        // R-type
        add(1, 6'h00, 1, 0, E_IFR);
        add(1, 6'h00, 0, 0, e_id(2'b00));
        add(1, 6'h00, 0, 0, E_EXR);
        add(1, 6'h00, 0, 0, E_WBR);
        // sw with one data wait
        add(1, 6'h2B, 1, 0, E_IFR);
        add(1, 6'h2B, 0, 0, e_id(2'b00));
        add(1, 6'h2B, 0, 0, E_EXM);
        add(1, 6'h2B, 0, 0, E_MWR);
        add(1, 6'h2B, 1, 0, E_MWRD);
        // j
        add(1, 6'h02, 1, 0, E_IFR);
        add(1, 6'h02, 0, 0, e_id(2'b00));
        add(1, 6'h02, 0, 0, E_JMP);
        // slti
        add(1, 6'h0A, 1, 0, E_IFR);
        add(1, 6'h0A, 0, 0, e_id(2'b00));
        add(1, 6'h0A, 0, 0, e_exi(2'b00, 3'b011));
        add(1, 6'h0A, 0, 0, e_wbi(2'b00));
        // andi
        add(1, 6'h0C, 1, 0, E_IFR);
        add(1, 6'h0C, 0, 0, e_id(2'b01));
        add(1, 6'h0C, 0, 0, e_exi(2'b01, 3'b100));
        add(1, 6'h0C, 0, 0, e_wbi(2'b01));
        // beq not taken, bne taken (zero=0)
        add(1, 6'h04, 1, 0, E_IFR);
        add(1, 6'h04, 0, 0, e_id(2'b00));
        add(1, 6'h04, 0, 0, e_br(1'b0));
        add(1, 6'h05, 1, 0, E_IFR);
        add(1, 6'h05, 0, 0, e_id(2'b00));
        add(1, 6'h05, 0, 0, e_br(1'b1));
        // reset held 3 clocks in the middle of a lw data wait
        add(1, 6'h23, 1, 0, E_IFR);
        add(1, 6'h23, 0, 0, e_id(2'b00));
        add(1, 6'h23, 0, 0, E_EXM);
        add(1, 6'h23, 0, 0, E_MRD);
        add(0, 6'h23, 0, 0, E_MRD);   // reset only takes effect at the edge
        add(0, 6'h23, 0, 0, E_IDLE);
        add(0, 6'h23, 0, 0, E_IDLE);
        add(1, 6'h23, 0, 0, E_IDLE);
        add(1, 6'h23, 0, 0, E_IFW);

        rst_i = 1'b0; opcode_i = '0; mem_ready_i = 1'b0; zero_i = 1'b0;
        @(posedge clk_i);

        foreach (vq[i]) begin
            @(negedge clk_i);
            rst_i       = vq[i].rst;
            opcode_i    = vq[i].op;
            mem_ready_i = vq[i].rdy;
            zero_i      = vq[i].zero;
            #1;
            check($sformatf("vec[%0d]", i), 32'(actual()), 32'(vq[i].exp));
            if (done_o === 1'b1) n_done++;
        end
        check("done_count", 32'(n_done), 32'd13);

        // j with 5 fetch waits: request must stay up, and the jump
        // completes in 3 + 5 = 8 cycles.
        cyc  = 0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk_i);
            rst_i       = 1'b1;
            opcode_i    = 6'h02;
            mem_ready_i = (k >= 5);
            zero_i      = 1'b0;
            #1;
            cyc++;
            if (k < 5) check($sformatf("jwait_req[%0d]", k),
                             32'({mem_req_o, ir_write_o, pc_write_o}), 32'(3'b100));
            if (done_o === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL j_timeout: no done_o within 30 cycles, required one");
        end else begin
            check("j_cycles", 32'(cyc), 32'd8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
